alu_psr_seq: RTL

Registered, parametrised successor to the combinational datapath ALU.
- Adds a handshaked issue port and a one-cycle registered result.
- Holds the processor status flags (C, L, F, N, Z) internally, so carry chains and compares persist across operations.
- Adds signed-amount logical/arithmetic shifts and a multi-cycle shift-add multiplier.
- Sits between the register-file read ports and the writeback mux; the controller uses the flag outputs for conditional branches.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_mul_iter.sv | 58 +++++
 rtl/alu_psr_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state constants for the sequential ALU.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_pkg;

  // Opcode values as seen on the issue port
  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_ADDU = 1;
  localparam int unsigned OP_SUB  = 2;
  localparam int unsigned OP_SUBU = 3;
  localparam int unsigned OP_CMP  = 4;
  localparam int unsigned OP_AND  = 5;
  localparam int unsigned OP_OR   = 6;
  localparam int unsigned OP_XOR  = 7;
  localparam int unsigned OP_LSH  = 8;
  localparam int unsigned OP_ASH  = 9;
  localparam int unsigned OP_MUL  = 10;

  // Bit positions inside the {C,L,F,N,Z} status register
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Issue FSM: either idle (accepting) or stepping the multiplier
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, low WIDTH_DATA bits of unsigned a*b.
// Latency: WIDTH_DATA cycles after start; done is high during the final step and product is valid then.
// Backpressure: none; start is ignored by the caller while busy, and a start always restarts the engine.
module alu_mul_iter #(
  parameter int WIDTH_DATA = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH_DATA-1:0] a,
  input  logic [WIDTH_DATA-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH_DATA-1:0] product
);

  localparam int CW = $clog2(WIDTH_DATA);

  logic [WIDTH_DATA-1:0] mcand;
  logic [WIDTH_DATA-1:0] mplier;
  logic [WIDTH_DATA-1:0] acc;
  logic [WIDTH_DATA-1:0] acc_nxt;
  logic [CW-1:0]         cnt;
  logic                  last;

  // The final partial sum is forwarded combinationally so the caller can
  // register it on the same edge that retires the last multiplier bit.
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign last    = (cnt == CW'(WIDTH_DATA - 1));
  assign done    = busy && last;
  assign product = acc_nxt;

  // One multiplier bit consumed per cycle; multiplicand walks left
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_psr_seq.sv
// Registered ALU with persistent {C,L,F,N,Z} status and an iterative multiplier.
// Latency: 1 cycle for single-cycle ops, WIDTH_DATA+1 cycles for MUL.
// Backpressure: in_ready drops for the whole MUL; requests must be held until accepted.
module alu_psr_seq #(
  parameter int WIDTH_DATA    = 16,
  parameter int WIDTH_CONTROL = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH_CONTROL-1:0] opcode,
  input  logic [WIDTH_DATA-1:0]    A,
  input  logic [WIDTH_DATA-1:0]    B,
  input  logic                     use_carry,
  input  logic                     flag_we,
  output logic [WIDTH_DATA-1:0]    result,
  output logic                     out_valid,
  output logic [4:0]               flags
);

  import alu_pkg::*;

  localparam int W           = WIDTH_DATA;
  localparam int WIDTH_SHIFT = $clog2(WIDTH_DATA);

  localparam logic [WIDTH_CONTROL-1:0] OPC_ADD  = WIDTH_CONTROL'(OP_ADD);
  localparam logic [WIDTH_CONTROL-1:0] OPC_ADDU = WIDTH_CONTROL'(OP_ADDU);
  localparam logic [WIDTH_CONTROL-1:0] OPC_SUB  = WIDTH_CONTROL'(OP_SUB);
  localparam logic [WIDTH_CONTROL-1:0] OPC_SUBU = WIDTH_CONTROL'(OP_SUBU);
  localparam logic [WIDTH_CONTROL-1:0] OPC_CMP  = WIDTH_CONTROL'(OP_CMP);
  localparam logic [WIDTH_CONTROL-1:0] OPC_AND  = WIDTH_CONTROL'(OP_AND);
  localparam logic [WIDTH_CONTROL-1:0] OPC_OR   = WIDTH_CONTROL'(OP_OR);
  localparam logic [WIDTH_CONTROL-1:0] OPC_XOR  = WIDTH_CONTROL'(OP_XOR);
  localparam logic [WIDTH_CONTROL-1:0] OPC_LSH  = WIDTH_CONTROL'(OP_LSH);
  localparam logic [WIDTH_CONTROL-1:0] OPC_ASH  = WIDTH_CONTROL'(OP_ASH);
  localparam logic [WIDTH_CONTROL-1:0] OPC_MUL  = WIDTH_CONTROL'(OP_MUL);

  logic [0:0]         state;
  logic               accept;
  logic               mul_start;
  logic               mul_fwe;
  logic               mul_busy;
  logic               mul_done;
  logic [W-1:0]       mul_prod;

  logic               cin;
  logic [W:0]         add_w;
  logic [W:0]         sub_w;
  logic [WIDTH_SHIFT:0] amt;
  logic [WIDTH_SHIFT:0] amt_mag;
  logic               amt_neg;
  logic               oversize;
  logic [W-1:0]       shl;
  logic [W-1:0]       shr;
  logic [W-1:0]       sar;

  logic [W-1:0]       alu_res;
  logic [4:0]         flag_nxt;
  logic               upd_nz;

  assign in_ready  = (state == ST_IDLE) && !mul_busy;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opcode == OPC_MUL);

  alu_mul_iter #(
    .WIDTH_DATA (WIDTH_DATA)
  ) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Adder/subtractor at W+1 bits so bit W carries the carry/borrow; cin comes from stored C
  always_comb begin
    cin   = use_carry & flags[FLAG_C];
    add_w = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, cin};
    sub_w = {1'b0, A} - {1'b0, B} - {{W{1'b0}}, cin};
  end

  // Signed shift amount: positive shifts left, negative shifts right; magnitude >= W saturates
  always_comb begin
    amt      = B[WIDTH_SHIFT:0];
    amt_neg  = amt[WIDTH_SHIFT];
    amt_mag  = amt_neg ? -amt : amt;
    oversize = (int'(amt_mag) >= W);
    shl      = oversize ? '0 : (A << amt_mag);
    shr      = oversize ? '0 : (A >> amt_mag);
    sar      = oversize ? {W{A[W-1]}} : $unsigned($signed(A) >>> amt_mag);
  end

  // Op mux and next-flag computation for single-cycle opcodes
  always_comb begin
    alu_res  = '0;
    flag_nxt = flags;
    upd_nz   = 1'b0;
    case (opcode)
      OPC_ADD, OPC_ADDU: begin
        alu_res          = add_w[W-1:0];
        flag_nxt[FLAG_C] = add_w[W];
        flag_nxt[FLAG_F] = (A[W-1] == B[W-1]) && (add_w[W-1] != A[W-1]);
        upd_nz           = 1'b1;
      end
      OPC_SUB, OPC_SUBU: begin
        alu_res          = sub_w[W-1:0];
        flag_nxt[FLAG_C] = sub_w[W];
        flag_nxt[FLAG_F] = (A[W-1] != B[W-1]) && (sub_w[W-1] != A[W-1]);
        upd_nz           = 1'b1;
      end
      OPC_CMP: begin
        alu_res          = A - B;
        flag_nxt[FLAG_L] = (A < B);
        flag_nxt[FLAG_N] = ($signed(A) < $signed(B));
        flag_nxt[FLAG_Z] = (A == B);
      end
      OPC_AND: begin
        alu_res = A & B;
        upd_nz  = 1'b1;
      end
      OPC_OR: begin
        alu_res = A | B;
        upd_nz  = 1'b1;
      end
      OPC_XOR: begin
        alu_res = A ^ B;
        upd_nz  = 1'b1;
      end
      OPC_LSH: begin
        alu_res = amt_neg ? shr : shl;
        upd_nz  = 1'b1;
      end
      OPC_ASH: begin
        alu_res = amt_neg ? sar : shl;
        upd_nz  = 1'b1;
      end
      default: begin
        alu_res = '0;
      end
    endcase
    if (upd_nz) begin
      flag_nxt[FLAG_N] = alu_res[W-1];
      flag_nxt[FLAG_Z] = (alu_res == '0);
    end
  end

  // Issue FSM, output registers and status register; MUL retires on the multiplier's done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
      mul_fwe   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == ST_MUL) begin
        if (mul_done) begin
          state     <= ST_IDLE;
          result    <= mul_prod;
          out_valid <= 1'b1;
          if (mul_fwe) begin
            flags[FLAG_N] <= mul_prod[W-1];
            flags[FLAG_Z] <= (mul_prod == '0);
          end
        end
      end else if (accept) begin
        if (opcode == OPC_MUL) begin
          state   <= ST_MUL;
          mul_fwe <= flag_we;
        end else begin
          result    <= alu_res;
          out_valid <= 1'b1;
          if (flag_we) begin
            flags <= flag_nxt;
          end
        end
      end
    end
  end

endmodule
